// File: rtl/tl_tx_arbiter_pkg.sv
// Shared types and helpers for the transaction-layer TX arbiter:
// memory request header layout, credit/beat sizing and FSM states.
package tl_tx_arbiter_pkg;

    localparam int unsigned TLP_DATA_W = 256;
    localparam int unsigned TLP_HDR_W  = 128;

    // One data credit is 4DW, one stream beat is 8DW.
    localparam logic [10:0] CREDIT_DW = 11'd4;
    localparam logic [10:0] BEAT_DW   = 11'd8;

    // DW0 sits in the low 32 bits so the header drops straight into beat[127:0].
    typedef struct packed {
        logic [31:0] addr_l;
        logic [31:0] addr_h;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic        t9;
        logic [2:0]  tc;
        logic        t8;
        logic        attr2;
        logic        ln;
        logic        th;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [1:0]  at;
        logic [1:0]  length_h;
        logic [7:0]  length_l;
    } tlp_memory_req_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } tx_arb_state_t;

    // A zero length field encodes the 1024DW maximum.
    function automatic logic [10:0] hdr_len_dw(input tlp_memory_req_hdr_t hdr);
        logic [9:0] raw;
        raw = {hdr.length_h, hdr.length_l};
        return (raw == 10'd0) ? 11'd1024 : {1'b0, raw};
    endfunction

    function automatic logic [8:0] hdr_pd_need(input tlp_memory_req_hdr_t hdr);
        return 9'((hdr_len_dw(hdr) + CREDIT_DW - 11'd1) / CREDIT_DW);
    endfunction

    function automatic logic [7:0] hdr_beats(input tlp_memory_req_hdr_t hdr);
        return 8'((hdr_len_dw(hdr) + BEAT_DW - 11'd1) / BEAT_DW);
    endfunction

endpackage

// File: rtl/tl_tx_arbiter_if.sv
// TLP beat stream towards the data link layer: sop/eop framed 256-bit
// beats with a valid/ready handshake.
interface tl_tx_arbiter_if;
    import tl_tx_arbiter_pkg::*;

    logic                  tlp_valid;
    logic [TLP_DATA_W-1:0] tlp_data;
    logic                  tlp_sop;
    logic                  tlp_eop;
    logic                  tlp_ready;

    modport master (
        output tlp_valid,
        output tlp_data,
        output tlp_sop,
        output tlp_eop,
        input  tlp_ready
    );

    modport slave (
        input  tlp_valid,
        input  tlp_data,
        input  tlp_sop,
        input  tlp_eop,
        output tlp_ready
    );

endinterface

// File: rtl/tl_fc_credit_chk.sv
// Flow-control credit tracker for one credit type: cumulative consumed
// counter and the modulo-2^W "enough credit" compare.
module tl_fc_credit_chk #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] limit_i,
    input  logic [W-1:0] need_i,
    input  logic         consume_i,
    output logic         ok_o
);

    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] consumed_q;
    logic [W-1:0] consumed_d;
    logic [W-1:0] slack_s;

    // Credit compare and next consumed count; both wrap at 2^W by design.
    always_comb begin
        slack_s = limit_i - (consumed_q + need_i);
        ok_o    = (slack_s <= HALF);
        if (consume_i) begin
            consumed_d = consumed_q + need_i;
        end else begin
            consumed_d = consumed_q;
        end
    end

    // Consumed counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            consumed_q <= {W{1'b0}};
        end else begin
            consumed_q <= consumed_d;
        end
    end

endmodule

// File: rtl/tl_tx_arbiter.sv
// TX arbiter: picks posted or non-posted work under credit and ordering
// rules and streams each TLP (header beat, then payload beats) to the DLL.
module tl_tx_arbiter
    import tl_tx_arbiter_pkg::*;
#(
    parameter int unsigned TX_DEPTH_LG2 = 3,
    parameter int unsigned PH_W         = 8,
    parameter int unsigned PD_W         = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p_hdr_empty_i,
    input  logic [TLP_HDR_W-1:0]    p_hdr_rdata_i,
    output logic                    p_hdr_rden_o,
    input  logic                    p_data_empty_i,
    input  logic [TLP_DATA_W-1:0]   p_data_rdata_i,
    output logic                    p_data_rden_o,
    input  logic [TX_DEPTH_LG2-1:0] p_payload_cnt_i,
    output logic                    p_sent_o,
    input  logic                    np_hdr_empty_i,
    input  logic [TLP_HDR_W-1:0]    np_hdr_rdata_i,
    output logic                    np_hdr_rden_o,
    input  logic                    fc_valid_i,
    input  logic [PH_W-1:0]         fc_ph_limit_i,
    input  logic [PD_W-1:0]         fc_pd_limit_i,
    input  logic [PH_W-1:0]         fc_nph_limit_i,
    tl_tx_arbiter_if.master         tlp_if
);

    tx_arb_state_t       state_q;
    tlp_memory_req_hdr_t hdr_q;
    logic                is_p_q;
    logic [7:0]          beat_cnt_q;

    tlp_memory_req_hdr_t p_hdr_s;
    logic [PH_W-1:0]     h_need_s;
    logic [PD_W-1:0]     pd_need_s;
    logic                ph_ok_s;
    logic                pd_ok_s;
    logic                nph_ok_s;
    logic                p_elig_s;
    logic                np_elig_s;
    logic                grant_p_s;
    logic                grant_np_s;

    logic                  tlp_valid_s;
    logic [TLP_DATA_W-1:0] tlp_data_s;
    logic                  tlp_sop_s;
    logic                  tlp_eop_s;

    assign p_hdr_s   = p_hdr_rdata_i;
    assign h_need_s  = {{(PH_W-1){1'b0}}, 1'b1};
    assign pd_need_s = {{(PD_W-9){1'b0}}, hdr_pd_need(p_hdr_s)};

    // NP is held back whenever any P header is queued, credit-blocked or not.
    always_comb begin
        p_elig_s   = fc_valid_i & ~p_hdr_empty_i
                   & (p_payload_cnt_i != {TX_DEPTH_LG2{1'b0}}) & ph_ok_s & pd_ok_s;
        np_elig_s  = fc_valid_i & ~np_hdr_empty_i & p_hdr_empty_i & nph_ok_s;
        grant_p_s  = (state_q == ST_IDLE) & p_elig_s;
        grant_np_s = (state_q == ST_IDLE) & ~p_elig_s & np_elig_s;
    end

    tl_fc_credit_chk #(.W(PH_W)) u_ph_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .limit_i   (fc_ph_limit_i),
        .need_i    (h_need_s),
        .consume_i (grant_p_s),
        .ok_o      (ph_ok_s)
    );

    tl_fc_credit_chk #(.W(PD_W)) u_pd_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .limit_i   (fc_pd_limit_i),
        .need_i    (pd_need_s),
        .consume_i (grant_p_s),
        .ok_o      (pd_ok_s)
    );

    tl_fc_credit_chk #(.W(PH_W)) u_nph_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .limit_i   (fc_nph_limit_i),
        .need_i    (h_need_s),
        .consume_i (grant_np_s),
        .ok_o      (nph_ok_s)
    );

    // Arbitration FSM: grant latches the header, HDR emits it, DATA streams payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            is_p_q     <= 1'b0;
            beat_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_p_s) begin
                        hdr_q   <= p_hdr_rdata_i;
                        is_p_q  <= 1'b1;
                        state_q <= ST_HDR;
                    end else if (grant_np_s) begin
                        hdr_q   <= np_hdr_rdata_i;
                        is_p_q  <= 1'b0;
                        state_q <= ST_HDR;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (tlp_if.tlp_ready) begin
                        if (is_p_q) begin
                            beat_cnt_q <= hdr_beats(hdr_q) - 8'd1;
                            state_q    <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (!p_data_empty_i && tlp_if.tlp_ready) begin
                        if (beat_cnt_q == 8'd0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 8'd1;
                        end
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Beat framing and FIFO pops decoded from the registered state.
    always_comb begin
        tlp_valid_s   = 1'b0;
        tlp_data_s    = {TLP_DATA_W{1'b0}};
        tlp_sop_s     = 1'b0;
        tlp_eop_s     = 1'b0;
        p_hdr_rden_o  = 1'b0;
        np_hdr_rden_o = 1'b0;
        p_data_rden_o = 1'b0;
        p_sent_o      = 1'b0;
        case (state_q)
            ST_HDR: begin
                tlp_valid_s   = 1'b1;
                tlp_sop_s     = 1'b1;
                tlp_eop_s     = ~is_p_q;
                tlp_data_s    = {{(TLP_DATA_W-TLP_HDR_W){1'b0}}, hdr_q};
                p_hdr_rden_o  = tlp_if.tlp_ready & is_p_q;
                np_hdr_rden_o = tlp_if.tlp_ready & ~is_p_q;
            end
            ST_DATA: begin
                tlp_valid_s   = ~p_data_empty_i;
                tlp_data_s    = p_data_rdata_i;
                tlp_eop_s     = (beat_cnt_q == 8'd0);
                p_data_rden_o = ~p_data_empty_i & tlp_if.tlp_ready;
                p_sent_o      = ~p_data_empty_i & tlp_if.tlp_ready & (beat_cnt_q == 8'd0);
            end
            default: begin
                tlp_valid_s = 1'b0;
            end
        endcase
    end

    assign tlp_if.tlp_valid = tlp_valid_s;
    assign tlp_if.tlp_data  = tlp_data_s;
    assign tlp_if.tlp_sop   = tlp_sop_s;
    assign tlp_if.tlp_eop   = tlp_eop_s;

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Scoreboard bench for tl_tx_arbiter: bench-side FIFO models feed the DUT,
// expected beats are queued at stimulus time and checked by a monitor.
module tb_tl_tx_arbiter;

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic         isp;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         p_hdr_empty;
    logic [127:0] p_hdr_rdata;
    logic         p_hdr_rden;
    logic         p_data_empty;
    logic [255:0] p_data_rdata;
    logic         p_data_rden;
    logic [2:0]   p_payload_cnt;
    logic         p_sent;
    logic         np_hdr_empty;
    logic [127:0] np_hdr_rdata;
    logic         np_hdr_rden;
    logic         fc_valid;
    logic [7:0]   fc_ph_limit;
    logic [11:0]  fc_pd_limit;
    logic [7:0]   fc_nph_limit;

    tl_tx_arbiter_if tlp_if ();

    tl_tx_arbiter #(.TX_DEPTH_LG2(3), .PH_W(8), .PD_W(12)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .p_hdr_empty_i   (p_hdr_empty),
        .p_hdr_rdata_i   (p_hdr_rdata),
        .p_hdr_rden_o    (p_hdr_rden),
        .p_data_empty_i  (p_data_empty),
        .p_data_rdata_i  (p_data_rdata),
        .p_data_rden_o   (p_data_rden),
        .p_payload_cnt_i (p_payload_cnt),
        .p_sent_o        (p_sent),
        .np_hdr_empty_i  (np_hdr_empty),
        .np_hdr_rdata_i  (np_hdr_rdata),
        .np_hdr_rden_o   (np_hdr_rden),
        .fc_valid_i      (fc_valid),
        .fc_ph_limit_i   (fc_ph_limit),
        .fc_pd_limit_i   (fc_pd_limit),
        .fc_nph_limit_i  (fc_nph_limit),
        .tlp_if          (tlp_if.master)
    );

    always #5 clk = ~clk;

    logic [127:0] p_hdr_q[$];
    logic [255:0] p_data_q[$];
    logic [127:0] np_hdr_q[$];
    exp_t         exp_q[$];

    int n_checks;
    int n_fail;
    int p_pushed;
    int sent_cnt;
    int pops_ph;
    int pops_pd;
    int pops_nph;
    logic saw_valid;
    logic pend_ph;
    logic pend_pd;
    logic pend_nph;
    logic [7:0]  ph_m;
    logic [11:0] pd_m;
    logic [7:0]  nph_m;
    logic [31:0] tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] make_hdr(input logic [9:0] len, input logic [31:0] t);
        return {t, ~t, 32'h0000_CAFE, 22'h0, len};
    endfunction

    function automatic logic [255:0] make_data(input logic [31:0] t, input int i);
        logic [31:0] w;
        w = t + 32'(i);
        return {8{w}};
    endfunction

    function automatic int len_of(input int len);
        return (len == 0) ? 1024 : len;
    endfunction

    task automatic refresh();
        int diff;
        p_hdr_empty  = (p_hdr_q.size() == 0);
        p_hdr_rdata  = p_hdr_empty ? 128'h0 : p_hdr_q[0];
        p_data_empty = (p_data_q.size() == 0);
        p_data_rdata = p_data_empty ? 256'h0 : p_data_q[0];
        np_hdr_empty = (np_hdr_q.size() == 0);
        np_hdr_rdata = np_hdr_empty ? 128'h0 : np_hdr_q[0];
        diff = p_pushed - sent_cnt;
        p_payload_cnt = (diff > 7) ? 3'd7 : 3'(diff);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_p(input int len);
        exp_t e;
        logic [127:0] h;
        int nb;
        tag = tag + 32'h100;
        h = make_hdr(10'(len), tag);
        p_hdr_q.push_back(h);
        e.data = {128'h0, h}; e.sop = 1'b1; e.eop = 1'b0; e.isp = 1'b1;
        exp_q.push_back(e);
        nb = (len_of(len) + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            p_data_q.push_back(make_data(tag, i));
            e.data = make_data(tag, i); e.sop = 1'b0; e.eop = (i == nb - 1); e.isp = 1'b1;
            exp_q.push_back(e);
        end
        ph_m = ph_m + 8'd1;
        pd_m = pd_m + 12'((len_of(len) + 3) / 4);
        p_pushed++;
        refresh();
    endtask

    task automatic push_np(input int len);
        exp_t e;
        logic [127:0] h;
        tag = tag + 32'h100;
        h = make_hdr(10'(len), tag);
        np_hdr_q.push_back(h);
        e.data = {128'h0, h}; e.sop = 1'b1; e.eop = 1'b1; e.isp = 1'b0;
        exp_q.push_back(e);
        nph_m = nph_m + 8'd1;
        refresh();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        step(2);
    endtask

    task automatic chk_credits(input string tagname);
        chk({tagname, "_ph"},  64'(dut.u_ph_chk.consumed_q),  64'(ph_m));
        chk({tagname, "_pd"},  64'(dut.u_pd_chk.consumed_q),  64'(pd_m));
        chk({tagname, "_nph"}, 64'(dut.u_nph_chk.consumed_q), 64'(nph_m));
    endtask

    // Monitor: compares every handshaken beat against the scoreboard head.
    task automatic mon_loop();
        exp_t e;
        logic         prev_stall;
        logic [255:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 256'h0;
        forever begin
            @(negedge clk);
            if (tlp_if.tlp_valid) saw_valid = 1'b1;
            if (prev_stall) begin
                chk("hold_valid", 64'(tlp_if.tlp_valid), 64'd1);
                chk_data("hold_data", tlp_if.tlp_data, prev_data);
            end
            prev_stall = tlp_if.tlp_valid & ~tlp_if.tlp_ready;
            prev_data  = tlp_if.tlp_data;
            if (tlp_if.tlp_valid && tlp_if.tlp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got beat %0h, expected no beat", tlp_if.tlp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk_data("beat_data", tlp_if.tlp_data, e.data);
                    chk("beat_sop", 64'(tlp_if.tlp_sop), 64'(e.sop));
                    chk("beat_eop", 64'(tlp_if.tlp_eop), 64'(e.eop));
                    chk("p_sent", 64'(p_sent), 64'(e.eop & e.isp));
                end
            end
            pend_ph  = p_hdr_rden;
            pend_pd  = p_data_rden;
            pend_nph = np_hdr_rden;
            if (p_hdr_rden)  pops_ph++;
            if (p_data_rden) pops_pd++;
            if (np_hdr_rden) pops_nph++;
            if (p_sent)      sent_cnt++;
        end
    endtask

    // FIFO model: applies the pops seen at the last handshake edge.
    task automatic pop_loop();
        forever begin
            @(posedge clk);
            #1;
            if (pend_ph && p_hdr_q.size() != 0)   void'(p_hdr_q.pop_front());
            if (pend_pd && p_data_q.size() != 0)  void'(p_data_q.pop_front());
            if (pend_nph && np_hdr_q.size() != 0) void'(np_hdr_q.pop_front());
            pend_ph = 1'b0; pend_pd = 1'b0; pend_nph = 1'b0;
            refresh();
        end
    endtask

    initial begin
        int lens[4];
        int pd0;
        clk = 1'b0; rst_n = 1'b0;
        tlp_if.tlp_ready = 1'b1;
        fc_valid = 1'b0; fc_ph_limit = 8'd0; fc_pd_limit = 12'd0; fc_nph_limit = 8'd0;
        n_checks = 0; n_fail = 0; p_pushed = 0; sent_cnt = 0;
        pops_ph = 0; pops_pd = 0; pops_nph = 0; saw_valid = 1'b0;
        pend_ph = 1'b0; pend_pd = 1'b0; pend_nph = 1'b0;
        ph_m = 8'd0; pd_m = 12'd0; nph_m = 8'd0; tag = 32'h1000_0000;
        refresh();
        fork
            mon_loop();
            pop_loop();
        join_none

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_valid", 64'(tlp_if.tlp_valid), 64'd0);
        chk("rst_sopeop", 64'({tlp_if.tlp_sop, tlp_if.tlp_eop}), 64'd0);
        chk_data("rst_data", tlp_if.tlp_data, 256'h0);
        chk("rst_rden", 64'({p_hdr_rden, p_data_rden, np_hdr_rden, p_sent}), 64'd0);
        chk_credits("rst");
        step(1);
        rst_n = 1'b1;
        step(2);

        // NP read only, first gated by fc_valid
        fc_ph_limit = 8'd8; fc_pd_limit = 12'd64; fc_nph_limit = 8'd8;
        push_np(16);
        saw_valid = 1'b0;
        step(6);
        chk("fc_gate", 64'(saw_valid), 64'd0);
        fc_valid = 1'b1;
        drain(50);
        chk("np_pops", 64'(pops_nph), 64'd1);
        chk_credits("np_only");

        // P credit-blocked with NP queued behind it
        fc_pd_limit = 12'd0;
        push_p(16);
        push_np(16);
        saw_valid = 1'b0;
        step(10);
        chk("np_withheld", 64'(saw_valid), 64'd0);
        chk("nph_unchanged", 64'(dut.u_nph_chk.consumed_q), 64'd1);
        fc_pd_limit = 12'd4;
        drain(60);
        chk_credits("order");

        // P write 16DW
        fc_pd_limit = 12'd64;
        push_p(16);
        drain(60);
        chk("sent_cnt", 64'(sent_cnt), 64'd2);
        chk("pd_pops", 64'(pops_pd), 64'd4);
        chk_credits("p16");

        // Backpressure in HDR and DATA
        tlp_if.tlp_ready = 1'b0;
        push_p(16);
        step(7);
        repeat (4) begin
            tlp_if.tlp_ready = 1'b1;
            step(1);
            tlp_if.tlp_ready = 1'b0;
            step(5);
        end
        tlp_if.tlp_ready = 1'b1;
        drain(60);
        chk("bp_pd_pops", 64'(pops_pd), 64'd6);
        chk("bp_ph_pops", 64'(pops_ph), 64'd3);
        chk_credits("bp");

        // Back-to-back lengths exercising the ceil rounding
        lens[0] = 5; lens[1] = 9; lens[2] = 1; lens[3] = 8;
        foreach (lens[i]) push_p(lens[i]);
        drain(100);
        chk_credits("lens");

        // 1024DW payload
        pd0 = pops_pd;
        fc_pd_limit = pd_m + 12'd256;
        push_p(0);
        drain(400);
        chk("len0_beats", 64'(pops_pd - pd0), 64'd128);
        chk_credits("len0");

        // Walk PH consumed up to 255
        while (ph_m != 8'd255) begin
            fc_ph_limit = ph_m + 8'd2;
            fc_pd_limit = pd_m + 12'd16;
            push_p(1);
            drain(30);
        end
        chk_credits("walk");

        // Credit wrap: limit 255 blocks, limit 1 passes and wraps to 0
        fc_ph_limit = 8'd255;
        fc_pd_limit = pd_m + 12'd16;
        push_p(16);
        saw_valid = 1'b0;
        step(10);
        chk("wrap_blocked", 64'(saw_valid), 64'd0);
        fc_ph_limit = 8'd1;
        drain(60);
        chk("wrap_ph_zero", 64'(dut.u_ph_chk.consumed_q), 64'd0);
        chk_credits("wrap");

        // Reset mid-TLP
        fc_ph_limit = ph_m + 8'd4;
        fc_pd_limit = pd_m + 12'd300;
        push_p(0);
        step(20);
        fc_valid = 1'b0;
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        chk("midrst_valid", 64'(tlp_if.tlp_valid), 64'd0);
        chk("midrst_ph", 64'(dut.u_ph_chk.consumed_q), 64'd0);
        chk("midrst_pd", 64'(dut.u_pd_chk.consumed_q), 64'd0);
        p_hdr_q.delete(); p_data_q.delete(); np_hdr_q.delete(); exp_q.delete();
        step(1);
        rst_n = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_tx_arbiter.md
Name: tl_tx_arbiter

Overview:
- Transaction-layer TX stage directly downstream of the AXI-slave request packer.
- Drains the P header FIFO, P data FIFO and NP header FIFO.
- Enforces PCIe flow-control credits and P-before-NP ordering.
- Emits complete TLPs as a 256-bit sop/eop beat stream to the data link layer.
- Returns p_sent_o to the packer's posted payload counter.

Parameters:
- TX_DEPTH_LG2, 3, width of the posted payload counter input; matches the packer's TX FIFO depth.
- PH_W, 8, header credit counter width (PH, NPH).
- PD_W, 12, data credit counter width (PD; 1 credit = 4DW = 16B).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- p_hdr_empty_i  input  1  P header FIFO empty
- p_hdr_rdata_i  input  128  P header (PCIE_PKG::tlp_memory_req_hdr_t), FIFO head
- p_hdr_rden_o  output  1  P header pop
- p_data_empty_i  input  1  P data FIFO empty
- p_data_rdata_i  input  256  P payload beat, FIFO head
- p_data_rden_o  output  1  P data pop
- p_payload_cnt_i  input  TX_DEPTH_LG2  count of fully-buffered P payloads
- p_sent_o  output  1  1-cycle pulse, one P TLP fully sent
- np_hdr_empty_i  input  1  NP header FIFO empty
- np_hdr_rdata_i  input  128  NP header, FIFO head
- np_hdr_rden_o  output  1  NP header pop
- fc_valid_i  input  1  DLL flow-control init done
- fc_ph_limit_i  input  PH_W  cumulative PH credit limit
- fc_pd_limit_i  input  PD_W  cumulative PD credit limit
- fc_nph_limit_i  input  PH_W  cumulative NPH credit limit
- tlp_valid_o  output  1  beat valid
- tlp_data_o  output  256  beat data
- tlp_sop_o  output  1  first beat of TLP
- tlp_eop_o  output  1  last beat of TLP
- tlp_ready_i  input  1  DLL accepts beat

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk.
  - State IDLE; all credit-consumed counters 0.
  - All outputs 0 (tlp_valid_o, sop/eop, every rden, p_sent_o, tlp_data_o).
- Header fields:
  - len_dw = {length_h, length_l}; value 0 means 1024.
  - pd_need = ceil(len_dw/4).
  - beats = ceil(len_dw/8).
- Credit check, modulo 2^W:
  - A type passes when (limit - (consumed + need)) mod 2^W <= 2^(W-1).
  - need = 1 for PH/NPH; need = pd_need for PD.
  - Nothing issues while fc_valid_i = 0.
- P eligible: ~p_hdr_empty_i, p_payload_cnt_i != 0, PH credit ok, PD credit ok.
- NP eligible: ~np_hdr_empty_i, p_hdr_empty_i, NPH credit ok.
  - NP never passes a queued P, even a credit-blocked one.
- IDLE:
  - If P eligible: grant P. Else if NP eligible: grant NP.
  - On grant: latch header into hdr_q and type into is_p_q; add need to the consumed counters (same edge); next state HDR.
  - No FIFO pop at grant.
- HDR:
  - tlp_valid_o = 1, tlp_sop_o = 1, tlp_data_o = {128'b0, hdr_q}.
  - tlp_eop_o = ~is_p_q.
  - On tlp_ready_i, pop the header FIFO (p_hdr_rden_o or np_hdr_rden_o, 1 cycle).
    - If P: beat_cnt <= beats-1; next DATA.
    - Else: next IDLE.
- DATA:
  - tlp_valid_o = ~p_data_empty_i; tlp_data_o = p_data_rdata_i.
  - tlp_eop_o = (beat_cnt == 0).
  - On valid & ready: p_data_rden_o = 1, beat_cnt decrements.
  - On the eop handshake: p_sent_o = 1 for that cycle; next IDLE.
- Grant-to-sop latency: 1 cycle. Back-to-back TLPs have one IDLE cycle between them.
- tlp_valid_o is held with data stable until tlp_ready_i; it never drops once raised within HDR.
- Consumed counters wrap naturally at 2^W.
- Limit changes mid-TLP do not affect a TLP already granted.
- Reset mid-TLP: abort to IDLE, counters cleared. The FIFOs are reset by the same rst_n.

Decomposition:
- PCIE_PKG:
  - tlp_memory_req_hdr_t.
  - Constants for credit unit (4DW) and beat size (8DW).
  - Enum tx_arb_state_t {IDLE, HDR, DATA}.
- One sub-module, tl_fc_credit_chk:
  - One per credit type; parameter W.
  - Holds the consumed counter, the modulo compare and the consume strobe.
  - Instantiated for PH, PD and NPH.

Test Plan:
- NP read only: fc limits PH=8, PD=64, NPH=8; one NP header, length 16 → single beat with sop=eop=1, data[127:0]=header; np_hdr_rden_o pulses once; NPH consumed=1.
- P write, length 16DW, 2 payload beats, p_payload_cnt=1:
  - Expect 3 beats: header(sop), D0, D1(eop).
  - p_sent_o pulses on the D1 handshake; PD consumed=4.
- P and NP pending together: P goes first. NP is withheld while P is credit-blocked (PD limit=0), and issues after P drains once the PD limit is raised to 4.
- Backpressure: tlp_ready_i low for 5 cycles in HDR and DATA → data/valid stable; no extra FIFO pops; beat count exact.
- Credit wrap: PH_W=8, consumed=255, limit=1 → next P is allowed (mod compare); consumed wraps to 0. With limit=255 and consumed=255 it is blocked.
- Length 0 (1024DW) P: expect 128 payload beats with eop on the 128th; PD consumed grows by 256.
